// File: rtl/pipeline_pkg.sv
// Shared next-address selector encodings and redirect controller state type.
package pipeline_pkg;
   localparam logic [2:0] SEL_SEQ   = 3'd0;
   localparam logic [2:0] SEL_BLT   = 3'd1;
   localparam logic [2:0] SEL_BEQ   = 3'd2;
   localparam logic [2:0] SEL_JAL   = 3'd3;
   localparam logic [2:0] SEL_JALR  = 3'd4;
   localparam logic [2:0] SEL_RESET = 3'd5;

   typedef enum logic [1:0] {
      S_BOOT   = 2'd0,
      S_RUN    = 2'd1,
      S_SHADOW = 2'd2
   } redirect_state_t;
endpackage

// File: rtl/pc_redirect_ctrl_branch_resolve.sv
// Combinational qualification of the EXMA control-transfer selector.
module branch_resolve
   import pipeline_pkg::*;
(
   input  logic       valid,
   input  logic [2:0] sel,
   input  logic       less,
   input  logic       zero,
   output logic       take,
   output logic       isCond,
   output logic       illegal
);
   always_comb begin
      take    = 1'b0;
      isCond  = 1'b0;
      illegal = 1'b0;
      if (valid) begin
         case (sel)
            SEL_SEQ:  take = 1'b0;
            SEL_BLT:  begin isCond = 1'b1; take = less; end
            SEL_BEQ:  begin isCond = 1'b1; take = zero; end
            SEL_JAL:  take = 1'b1;
            SEL_JALR: take = 1'b1;
            default:  illegal = 1'b1;
         endcase
      end
   end
endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC redirect sequencer: boot, run, and wrong-path shadow window.
// Optional statistics counters enabled by defining BRANCH_STATS_EN.
//  state    | meaning
//  S_BOOT   | PC forced to 0, pipeline flushed, BOOT_CYCLES long
//  S_RUN    | EXMA selector qualified and routed to the next-address mux
//  S_SHADOW | wrong-path instructions ignored for SHADOW_CYCLES unstalled cycles
module pc_redirect_ctrl
   import pipeline_pkg::*;
#(
   parameter int BOOT_CYCLES   = 4,
   parameter int SHADOW_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exma_valid,
   input  logic [2:0]  exma_sel,
   input  logic        exma_less,
   input  logic        exma_zero,
   input  logic        stall,
   output logic [2:0]  addr_sel,
   output logic        pc_en,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        redirect,
   output logic        illegal_sel,
   output logic        booting,
   output logic [31:0] taken_cnt,
   output logic [31:0] branch_cnt
);
   localparam logic [1:0] BOOT_LAST   = 2'(BOOT_CYCLES - 1);
   localparam logic [1:0] SHADOW_LAST = 2'(SHADOW_CYCLES - 1);

   redirect_state_t state;
   logic [1:0]      cnt;
   logic            live, take, isCond, illegal;

   assign live = exma_valid & ~stall & (state == S_RUN);

   branch_resolve uResolve (
      .valid   (live),
      .sel     (exma_sel),
      .less    (exma_less),
      .zero    (exma_zero),
      .take    (take),
      .isCond  (isCond),
      .illegal (illegal)
   );

   always_comb begin
      addr_sel    = SEL_SEQ;
      pc_en       = ~stall;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      redirect    = 1'b0;
      illegal_sel = 1'b0;
      booting     = 1'b0;
      case (state)
         S_BOOT: begin
            addr_sel   = SEL_RESET;
            pc_en      = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            booting    = 1'b1;
         end
         S_RUN: begin
            addr_sel    = take ? exma_sel : SEL_SEQ;
            redirect    = take;
            flush_ifid  = take;
            flush_idex  = take;
            illegal_sel = illegal;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_BOOT;
         cnt   <= '0;
      end else begin
         case (state)
            S_BOOT: begin
               if (cnt == BOOT_LAST) begin
                  state <= S_RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            S_RUN: begin
               if (take) begin
                  state <= S_SHADOW;
                  cnt   <= '0;
               end
            end
            S_SHADOW: begin
               if (!stall) begin
                  if (cnt == SHADOW_LAST) begin
                     state <= S_RUN;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 2'd1;
                  end
               end
            end
            default: begin
               state <= S_BOOT;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   // live already excludes stalled cycles, so both counters freeze on stall
   always_ff @(posedge clk) begin
      if (reset) begin
         taken_cnt  <= '0;
         branch_cnt <= '0;
      end else begin
         if (take)
            taken_cnt <= taken_cnt + 32'd1;
         if (isCond)
            branch_cnt <= branch_cnt + 32'd1;
      end
   end
`else
   assign taken_cnt  = '0;
   assign branch_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;
`ifdef BRANCH_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        exma_valid;
   logic [2:0]  exma_sel;
   logic        exma_less;
   logic        exma_zero;
   logic        stall;
   logic [2:0]  addr_sel;
   logic        pc_en, flush_ifid, flush_idex, redirect, illegal_sel, booting;
   logic [31:0] taken_cnt, branch_cnt;

   int total = 0;
   int passed = 0;

   pc_redirect_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .exma_valid  (exma_valid),
      .exma_sel    (exma_sel),
      .exma_less   (exma_less),
      .exma_zero   (exma_zero),
      .stall       (stall),
      .addr_sel    (addr_sel),
      .pc_en       (pc_en),
      .flush_ifid  (flush_ifid),
      .flush_idex  (flush_idex),
      .redirect    (redirect),
      .illegal_sel (illegal_sel),
      .booting     (booting),
      .taken_cnt   (taken_cnt),
      .branch_cnt  (branch_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] st(input int n);
      return STATS_ON ? 32'(n) : 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] s, input logic l, input logic z, input logic stl);
      exma_valid = v;
      exma_sel   = s;
      exma_less  = l;
      exma_zero  = z;
      stall      = stl;
      #1;
   endtask

   task automatic quiet(input string tag, input logic expPcEn);
      check({tag, ".addr_sel"}, 32'(addr_sel), 32'd0);
      check({tag, ".redirect"}, 32'(redirect), 32'd0);
      check({tag, ".flush"}, 32'({flush_ifid, flush_idex}), 32'd0);
      check({tag, ".pc_en"}, 32'(pc_en), 32'(expPcEn));
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
      check("rst.booting", 32'(booting), 32'd1);
      check("rst.addr_sel", 32'(addr_sel), 32'd5);
      check("rst.taken_cnt", taken_cnt, 32'd0);
      check("rst.branch_cnt", branch_cnt, 32'd0);

      // boot window: exactly four cycles after release, stall ignored
      reset = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("boot.addr_sel", 32'(addr_sel), 32'd5);
         check("boot.flush", 32'({flush_ifid, flush_idex}), 32'd3);
         check("boot.pc_en", 32'(pc_en), 32'd1);
         check("boot.redirect", 32'(redirect), 32'd0);
         tick();
      end
      drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("run.booting", 32'(booting), 32'd0);
      quiet("run", 1'b1);

      // beq taken, then shadow ignores a live jal for two cycles
      drive(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
      check("beq.addr_sel", 32'(addr_sel), 32'd2);
      check("beq.redirect", 32'(redirect), 32'd1);
      check("beq.flush", 32'({flush_ifid, flush_idex}), 32'd3);
      tick();
      drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
      quiet("shadow0", 1'b1);
      tick();
      quiet("shadow1", 1'b1);
      tick();
      check("beq.taken_cnt", taken_cnt, st(1));
      check("beq.branch_cnt", branch_cnt, st(1));

      // blt not taken
      drive(1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
      quiet("blt_nt", 1'b1);
      tick();
      check("blt_nt.branch_cnt", branch_cnt, st(2));
      check("blt_nt.taken_cnt", taken_cnt, st(1));

      // beq not taken
      drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
      quiet("beq_nt", 1'b1);
      tick();

      // blt taken, shadow counter frozen while stalled
      drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
      check("blt.addr_sel", 32'(addr_sel), 32'd1);
      check("blt.redirect", 32'(redirect), 32'd1);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
      quiet("shstall", 1'b0);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
      quiet("shstall.last", 1'b1);
      tick();
      check("blt.taken_cnt", taken_cnt, st(2));
      check("blt.branch_cnt", branch_cnt, st(4));

      // jalr held under stall for three cycles resolves once
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
         quiet("jalr_stall", 1'b0);
         tick();
      end
      check("jalr_stall.taken_cnt", taken_cnt, st(2));
      drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
      check("jalr.addr_sel", 32'(addr_sel), 32'd4);
      check("jalr.redirect", 32'(redirect), 32'd1);
      check("jalr.pc_en", 32'(pc_en), 32'd1);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("jalr.taken_cnt", taken_cnt, st(3));
      tick();
      tick();

      // illegal selector: one-cycle pulse, treated as sequential
      drive(1'b1, 3'd6, 1'b1, 1'b1, 1'b0);
      check("ill.pulse", 32'(illegal_sel), 32'd1);
      quiet("ill", 1'b1);
      tick();
      drive(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
      check("ill.novalid", 32'(illegal_sel), 32'd0);
      drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      check("seq.illegal", 32'(illegal_sel), 32'd0);
      quiet("seq", 1'b1);

      // jal then reset mid-shadow
      drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
      check("jal.addr_sel", 32'(addr_sel), 32'd3);
      check("jal.redirect", 32'(redirect), 32'd1);
      tick();
      check("jal.taken_cnt", taken_cnt, st(4));
      reset = 1'b1;
      drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      check("rst2.booting", 32'(booting), 32'd1);
      check("rst2.addr_sel", 32'(addr_sel), 32'd5);
      check("rst2.taken_cnt", taken_cnt, 32'd0);
      check("rst2.branch_cnt", branch_cnt, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
